lsu_bus_if: RTL and testbench
=============================

// Module: lsu_bus_if
// PURPOSE
//   Load/store unit between the MEM stage of the pipelined datapath and an external
//   single-master data bus with wait states. Turns MEM-stage load/store requests into
//   bus cycles and produces byte-lane selects plus aligned store data. Returns
//   sign-/zero-extended load data to the MEM/WB register and holds the pipeline via a
//   stall request until the bus acks, errors or times out.
// PARAMETERS
//   DATA_WIDTH  32   data path width (fixed 32 for RV32I lane logic)
//   ADDR_WIDTH  32   byte address width
//   TIMEOUT     255  bus cycles in BUS with no ack/err before the access is aborted
// PORTS
//   clk             in   1   system clock
//   rst             in   1   asynchronous, active-low reset
//   i_req_M         in   1   MEM-stage load or store valid (held while o_stall_M=1)
//   i_we_M          in   1   1=store, 0=load
//   i_funct3_M      in   3   RV32I width/sign code of the access
//   i_addr_M        in   32  byte address (ALU result)
//   i_wdata_M       in   32  store data (rs2, low bits significant)
//   o_rdata_M       out  32  extended load data, valid in DONE
//   o_stall_M       out  1   hold IF..MEM stages
//   o_misaligned_M  out  1   1-cycle pulse: misaligned access rejected
//   o_bus_err_M     out  1   1-cycle pulse: bus error/timeout/illegal funct3
//   o_bus_cyc       out  1   bus cycle active
//   o_bus_we        out  1   bus write
//   o_bus_addr      out  32  word-aligned address {addr[31:2],2'b00}
//   o_bus_wdata     out  32  lane-replicated store data
//   o_bus_sel       out  4   byte-lane enables
//   i_bus_ack       in   1   bus transfer complete
//   i_bus_rdata     in   32  bus read data, valid with ack
//   i_bus_err       in   1   bus error termination
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; all outputs 0; timeout counter 0.
//   FSM IDLE -> BUS -> DONE -> IDLE.
//   IDLE: i_req_M & legal & aligned -> latch we/funct3/addr[1:0]/addr/sel/wdata; go BUS.
//     o_stall_M asserted combinationally in this cycle.
//   BUS: o_bus_cyc=1, all bus outputs stable from registers; o_stall_M=1.
//     i_bus_err -> DONE with error flag. Err wins over a same-cycle ack.
//     i_bus_ack -> capture extracted load data; DONE.
//     Counter reaching TIMEOUT with neither -> drop cyc; DONE with error flag.
//   DONE: o_stall_M=0 (pipeline advances, held request is consumed, never relaunched).
//     o_bus_err_M=error flag. Return to IDLE.
//   Minimum latency with zero-wait ack: 2 stall cycles; result in 3rd cycle.
//   o_rdata_M is registered and holds until the next load completes. 0 on error.
//   Stores update o_rdata_M to 0.
//   Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//   Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
//   Misalignment: H with addr[0]=1; W with addr[1:0]!=0.
//     No bus cycle, no stall; o_misaligned_M pulses while in IDLE.
//   Illegal funct3: no bus cycle, no stall; o_bus_err_M pulses while in IDLE.
//   Store lanes:
//     SB: sel=4'b0001<<addr[1:0], wdata={4{b}}
//     SH: sel=4'b0011<<{addr[1],1'b0}, wdata={2{h}}
//     SW: sel=4'b1111
//   Loads: sel as above; data=rdata>>(8*addr[1:0]), then sign/zero-extend to 32.
//   Reset mid-access: o_bus_cyc falls immediately with rst; the access is lost.
//   i_req_M=0 while in BUS or DONE is ignored; the access always completes.
// STRUCTURE
//   Shared package osiris_i_pkg: funct3 load/store codes; FSM state encodings;
//     lane-select base patterns.
//   Sub-module lsu_align (combinational) provides:
//     sel/wdata generation, load extraction/extension, misalign/illegal detect.
//   Top level holds the FSM, timeout counter and capture registers.
// TESTING
//   SW 0x1000, 0xDEADBEEF, ack 0 wait ->
//     sel=1111, cyc 1 cycle, stall 2 cycles, no error
//   LB 0x1003, bus returns 0x80AA55CC, ack after 3 waits ->
//     sel=1000, o_rdata_M=0xFFFFFF80, stall 5 cycles
//   LHU 0x1002, rdata 0x8001xxxx -> sel=1100, o_rdata_M=0x00008001
//   LW 0x1001 ->
//     o_misaligned_M 1-cycle pulse, cyc never rises, stall never rises
//   LW with no ack, TIMEOUT=4 ->
//     cyc high exactly 4 cycles, o_bus_err_M pulse, o_rdata_M=0, FSM IDLE
//   rst low mid-BUS with ack+err asserted together before reset ->
//     err wins (o_bus_err_M); reset drops cyc/stall asynchronously, outputs 0

Source files
------------

// File: rtl/osiris_i_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU FSM encodings,
// byte-lane base patterns and the latched bus request record.
package osiris_i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SEL_B = 4'b0001;
    localparam logic [3:0] SEL_H = 4'b0011;
    localparam logic [3:0] SEL_W = 4'b1111;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/lsu_bus_if_if.sv
// Single-master data bus with wait states: the LSU drives the master side,
// memory/peripherals answer on the slave side with ack or err.
interface lsu_bus_if_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_cyc;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [3:0]            bus_sel;
    logic                  bus_ack;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_err;

    modport master (
        output bus_cyc, bus_we, bus_addr, bus_wdata, bus_sel,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_cyc, bus_we, bus_addr, bus_wdata, bus_sel,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational RV32I lane logic: request-side lane select, store data replication
// and legality checks, plus completion-side load extraction and extension.
module lsu_align
    import osiris_i_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] lane_wdata,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        sel        = '0;
        lane_wdata = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_B: begin
                sel        = SEL_B << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            F3_H: begin
                sel        = SEL_H << {addr_lo[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                sel        = SEL_W;
                lane_wdata = wdata;
                misaligned = |addr_lo;
            end
            // Unsigned widths only exist for loads; as a store they are illegal.
            F3_BU: begin
                illegal = we;
                sel     = SEL_B << addr_lo;
            end
            F3_HU: begin
                illegal    = we;
                sel        = SEL_H << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    ld_data = shifted;
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_if.sv
// MEM-stage load/store unit: launches one bus cycle per legal aligned access,
// stalls the pipeline until ack/err/timeout and returns extended load data.
module lsu_bus_if
    import osiris_i_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_M,
    input  logic                  i_we_M,
    input  logic [2:0]            i_funct3_M,
    input  logic [ADDR_WIDTH-1:0] i_addr_M,
    input  logic [DATA_WIDTH-1:0] i_wdata_M,
    output logic [DATA_WIDTH-1:0] o_rdata_M,
    output logic                  o_stall_M,
    output logic                  o_misaligned_M,
    output logic                  o_bus_err_M,
    lsu_bus_if_if.master          bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      tmo_cnt;
    logic                  err_q;
    req_t                  req_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        req_misaligned;
    logic        req_illegal;
    logic [31:0] ld_data;
    logic        idle;
    logic        in_bus;
    logic        in_done;
    logic        launch;

    lsu_align u_align (
        .we         (i_we_M),
        .funct3     (i_funct3_M),
        .addr_lo    (i_addr_M[1:0]),
        .wdata      (i_wdata_M),
        .ld_funct3  (req_q.funct3),
        .ld_off     (req_q.addr[1:0]),
        .rdata      (bus.bus_rdata),
        .sel        (req_sel),
        .lane_wdata (req_wdata),
        .misaligned (req_misaligned),
        .illegal    (req_illegal),
        .ld_data    (ld_data)
    );

    // Request-side decode is combinational, so gate it with reset to keep outputs 0.
    assign idle    = rst & (state == ST_IDLE);
    assign in_bus  = (state == ST_BUS);
    assign in_done = (state == ST_DONE);
    assign launch  = idle & i_req_M & ~req_illegal & ~req_misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (launch) begin
                        state        <= ST_BUS;
                        tmo_cnt      <= '0;
                        req_q.we     <= i_we_M;
                        req_q.funct3 <= i_funct3_M;
                        req_q.addr   <= i_addr_M;
                        req_q.sel    <= req_sel;
                        req_q.wdata  <= req_wdata;
                    end
                end
                ST_BUS: begin
                    // Error termination takes priority over a same-cycle ack.
                    if (bus.bus_err) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_DONE;
                    end else if (bus.bus_ack) begin
                        rdata_q <= req_q.we ? '0 : ld_data;
                        state   <= ST_DONE;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_rdata_M      = rdata_q;
    assign o_stall_M      = launch | in_bus;
    assign o_misaligned_M = idle & i_req_M & ~req_illegal & req_misaligned;
    assign o_bus_err_M    = (idle & i_req_M & req_illegal) | (in_done & err_q);

    assign bus.bus_cyc   = in_bus;
    assign bus.bus_we    = in_bus & req_q.we;
    assign bus.bus_addr  = in_bus ? {req_q.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.bus_wdata = in_bus ? req_q.wdata : '0;
    assign bus.bus_sel   = in_bus ? req_q.sel : '0;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: directed accesses followed by random ones, each scored
// against a width/offset reference model of the RV32I load/store rules.
module tb_lsu_bus_if;

    localparam int TMO    = 4;
    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_TMO  = 3;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_out;
    logic        stall;
    logic        misal;
    logic        berr;

    int          tests;
    int          failed;
    logic [31:0] model_rdata;

    lsu_bus_if_if bus ();

    lsu_bus_if #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_M        (req),
        .i_we_M         (we),
        .i_funct3_M     (f3),
        .i_addr_M       (addr),
        .i_wdata_M      (wdata),
        .o_rdata_M      (rdata_out),
        .o_stall_M      (stall),
        .o_misaligned_M (misal),
        .o_bus_err_M    (berr),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference rules: access size in bytes, legality and lane arithmetic.
    function automatic int ref_size(input logic [2:0] code);
        case (code)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic st, input logic [2:0] code);
        if (st) return (code == 3'd0) || (code == 3'd1) || (code == 3'd2);
        return ref_size(code) != 0;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [2:0] code, input logic [31:0] a);
        int sz;
        sz = ref_size(code);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] code, input logic [31:0] d);
        int sz;
        sz = ref_size(code);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] code, input logic [31:0] d, input logic [31:0] a);
        int          sz;
        logic [31:0] v;
        logic [31:0] mask;
        logic        is_signed;
        sz = ref_size(code);
        v  = d >> (8 * (a % 4));
        if (sz == 4) return v;
        mask      = (32'd1 << (8 * sz)) - 32'd1;
        v         = v & mask;
        is_signed = (code == 3'd0) || (code == 3'd1);
        if (is_signed && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_access(input logic st, input logic [2:0] code, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd, input int waits,
                              input int mode, input string tag);
        int          cyc_n;
        int          stall_n;
        int          err_n;
        int          mis_n;
        logic        done;
        logic        resp;
        logic [3:0]  sel_seen;
        logic [31:0] addr_seen;
        logic [31:0] wd_seen;
        logic        we_seen;
        logic [31:0] rd_done;
        logic        legal;
        logic        mis;
        logic        go;
        logic        fail_term;
        logic [31:0] exp_rd;
        int          sz;

        sz        = ref_size(code);
        legal     = ref_legal(st, code);
        mis       = legal && ((a % sz) != 0);
        go        = legal && !mis;
        fail_term = (mode == M_TMO) || (mode == M_ERR) || (mode == M_BOTH);
        cyc_n = 0; stall_n = 0; err_n = 0; mis_n = 0;
        done = 1'b0; sel_seen = '0; addr_seen = '0; wd_seen = '0; we_seen = 1'b0; rd_done = '0;

        for (int c = 0; c < 24 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                req = 1'b1; we = st; f3 = code; addr = a; wdata = d;
            end
            resp          = (mode != M_TMO) && (c == waits + 1);
            bus.bus_ack   = resp && (mode != M_ERR);
            bus.bus_err   = resp && (mode != M_ACK);
            bus.bus_rdata = resp ? rd : $urandom;
            @(negedge clk);
            if (stall) stall_n++;
            if (bus.bus_cyc) begin
                if (cyc_n == 0) begin
                    sel_seen = bus.bus_sel; addr_seen = bus.bus_addr;
                    wd_seen = bus.bus_wdata; we_seen = bus.bus_we;
                end
                cyc_n++;
            end
            if (berr) err_n++;
            if (misal) mis_n++;
            if (!stall) begin
                done    = 1'b1;
                rd_done = rdata_out;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);

        @(posedge clk); #1;
        req = 1'b0; bus.bus_ack = 1'b0; bus.bus_err = 1'b0;
        @(negedge clk);
        check({tag, "_after_quiet"}, {28'd0, stall, bus.bus_cyc, berr, misal}, 32'd0);

        if (go) exp_rd = (fail_term || st) ? 32'd0 : ref_load(code, rd, a);
        else    exp_rd = model_rdata;
        model_rdata = exp_rd;

        check({tag, "_stall_cycles"}, 32'(stall_n), go ? 32'((mode == M_TMO) ? TMO + 1 : waits + 2) : 32'd0);
        check({tag, "_cyc_cycles"}, 32'(cyc_n), go ? 32'((mode == M_TMO) ? TMO : waits + 1) : 32'd0);
        check({tag, "_err_pulse"}, 32'(err_n), (!legal || (go && fail_term)) ? 32'd1 : 32'd0);
        check({tag, "_misaligned_pulse"}, 32'(mis_n), mis ? 32'd1 : 32'd0);
        check({tag, "_rdata"}, rd_done, exp_rd);
        check({tag, "_rdata_hold"}, rdata_out, exp_rd);
        if (go) begin
            check({tag, "_sel"}, {28'd0, sel_seen}, {28'd0, ref_sel(code, a)});
            check({tag, "_addr"}, addr_seen, a & ~32'd3);
            check({tag, "_we"}, 32'(we_seen), 32'(st));
            if (st) check({tag, "_wdata"}, wd_seen, ref_store(code, d));
        end
    endtask

    initial begin
        tests = 0; failed = 0; model_rdata = '0;
        rst = 1'b0; req = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h1000; wdata = '0;
        bus.bus_ack = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = '0;

        repeat (2) @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_cyc", 32'(bus.bus_cyc), 32'd0);
        check("reset_rdata", rdata_out, 32'd0);
        check("reset_pulses", {30'd0, berr, misal}, 32'd0);
        check("reset_bus_outs", {27'd0, bus.bus_we, bus.bus_sel} | bus.bus_addr | bus.bus_wdata, 32'd0);
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(negedge clk);

        run_access(1'b1, 3'd2, 32'h1000, 32'hDEAD_BEEF, 32'h0, 0, M_ACK, "sw_zero_wait");
        run_access(1'b0, 3'd0, 32'h1003, 32'h0, 32'h80AA_55CC, 3, M_ACK, "lb_3wait");
        run_access(1'b0, 3'd5, 32'h1002, 32'h0, 32'h8001_1234, 1, M_ACK, "lhu");
        run_access(1'b0, 3'd2, 32'h1001, 32'h0, 32'h0, 0, M_ACK, "lw_misaligned");
        run_access(1'b0, 3'd1, 32'h1001, 32'h0, 32'h0, 0, M_ACK, "lh_misaligned");
        run_access(1'b1, 3'd4, 32'h1000, 32'h0, 32'h0, 0, M_ACK, "sbu_illegal");
        run_access(1'b0, 3'd3, 32'h1000, 32'h0, 32'h0, 0, M_ACK, "ld_illegal");
        run_access(1'b0, 3'd4, 32'h1001, 32'h0, 32'hFFFF_F0FF, 0, M_ACK, "lbu");
        run_access(1'b0, 3'd2, 32'h1004, 32'h0, 32'h1234_5678, 2, M_TMO, "lw_timeout");
        run_access(1'b0, 3'd2, 32'h1008, 32'h0, 32'hCAFE_F00D, 2, M_ACK, "lw_ok");
        run_access(1'b0, 3'd2, 32'h100C, 32'h0, 32'hCAFE_F00D, 1, M_BOTH, "lw_ack_err_same");
        run_access(1'b1, 3'd1, 32'h1006, 32'h0000_A5C3, 32'h0, 0, M_ERR, "sh_err");

        for (int i = 0; i < 60; i++) begin
            logic        st;
            logic [2:0]  code;
            logic [31:0] a;
            int          r;
            int          mode;
            st   = 1'($urandom);
            code = 3'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (st) code = 3'($urandom_range(0, 2));
                else    code = (ref_size(code) == 0) ? 3'd2 : code;
            end
            a = 32'h4000 | ($urandom & 32'hFFC) | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            mode = (r < 6) ? M_ACK : (r < 8) ? M_ERR : (r == 8) ? M_BOTH : M_TMO;
            run_access(st, code, a, $urandom, $urandom, $urandom_range(0, 3), mode,
                       $sformatf("rnd%0d", i));
        end

        run_access(1'b0, 3'd2, 32'h3000, 32'h0, 32'h1357_9BDF, 1, M_ACK, "lw_pre_reset");
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h3004;
        @(posedge clk); #1;
        @(negedge clk);
        check("midbus_cyc", 32'(bus.bus_cyc), 32'd1);
        check("midbus_stall", 32'(stall), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_cyc", 32'(bus.bus_cyc), 32'd0);
        check("async_rst_stall", 32'(stall), 32'd0);
        check("async_rst_rdata", rdata_out, 32'd0);
        check("async_rst_pulses", {30'd0, berr, misal}, 32'd0);
        check("async_rst_sel", {28'd0, bus.bus_sel}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_rdata = '0;
        run_access(1'b0, 3'd1, 32'h5002, 32'h0, 32'h7FFF_0000, 0, M_ACK, "lh_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
